// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Define SEG_LZ_BLANK_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
  localparam logic [DigW-1:0] DigLast   = DigW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StOff, StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DigW-1:0]         dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    frame_done_q;

  logic                    frame_end;
  logic                    commit;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   oh_d;
  logic [3:0]              nib;
  logic                    lz_hit;

  function automatic logic [6:0] decode(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan sequencing: slot counter, digit index and phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    frame_end = 1'b0;
    if (!scan_en) begin
      state_d = StOff;
      cnt_d   = '0;
      dig_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          cnt_d   = '0;
          dig_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? StDrive : StBlank;
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (BLANK_CYCLES == 0 || cnt_q == BlankLast) state_d = StDrive;
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            cnt_d     = '0;
            frame_end = (dig_q == DigLast);
            dig_d     = frame_end ? '0 : dig_q + 1'b1;
            state_d   = (BLANK_CYCLES == 0) ? StDrive : StBlank;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StBlank;
      endcase
    end
  end

  // Pending value only lands at a frame boundary (or immediately while dark).
  always_comb begin
    commit       = pend_valid_q && (frame_end || state_q == StOff);
    accept       = load_valid && !pend_valid_q;
    disp_d       = commit ? pend_q : disp_q;
    pend_d       = accept ? load_data : pend_q;
    pend_valid_d = pend_valid_q;
    if (accept) begin
      pend_valid_d = 1'b1;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    oh_d = '0;
    nib  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      oh_d[i] = (dig_d == DigW'(i));
      if (oh_d[i]) nib = disp_d[4*i +: 4];
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  lz_acc;

  // lz[i] set when digit i and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    lz     = '0;
    lz_acc = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_acc = lz_acc & (disp_d[4*i +: 4] == 4'h0);
      lz[i]  = lz_acc;
    end
    lz_hit = |(lz & oh_d);
  end
`else
  assign lz_hit = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (state_d == StDrive) begin
      an_d  = ~(oh_d & digit_en);
      seg_d = lz_hit ? 7'h7F : decode(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      dig_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_end;
    end
  end

  assign load_ready = !pend_valid_q;
  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a time-based reference model.
// Define SEG_LZ_BLANK_EN to also exercise leading-zero blanking.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [3:0]  digit_en = 4'h0;
  logic [15:0] load_data = 16'h0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  // Model: m_t counts edges since the current scan started; slot = m_t/8, phase = m_t%8.
  bit          m_off = 1'b0;
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_pflag = 1'b0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_ready;
  logic        exp_fd;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .digit_en  (digit_en),
    .load_data (load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [15:0] disp, input int d);
    logic [6:0]  tab [16];
    logic [15:0] sh;
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sh = disp >> (4 * d);
`ifdef SEG_LZ_BLANK_EN
    if (d > 0 && sh == 16'h0) return 7'h7F;
`endif
    return tab[sh[3:0]];
  endfunction

  // Advance one clock edge, update the model, then settle 1 time unit.
  task automatic tick();
    bit fe;
    bit off_before;
    int d;
    @(posedge clk);
    off_before = m_off;
    fe = 1'b0;
    if (!rst_n) begin
      m_off = 1'b0; m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pflag = 1'b0;
    end else begin
      if (!scan_en) begin
        m_off = 1'b1;
      end else if (m_off) begin
        m_off = 1'b0;
        m_t = 0;
      end else begin
        m_t++;
        fe = (m_t % 32 == 0);
      end
      if (m_pflag) begin
        if (fe || off_before) begin
          m_disp = m_pend;
          m_pflag = 1'b0;
        end
      end else if (load_valid) begin
        m_pend = load_data;
        m_pflag = 1'b1;
      end
    end
    exp_ready = !m_pflag;
    exp_fd = fe;
    if (!rst_n || m_off || (m_t % 8) < 2) begin
      exp_an = 4'hF;
      exp_seg = 7'h7F;
    end else begin
      d = (m_t / 8) % 4;
      exp_an = ~((4'b0001 << d) & digit_en);
      exp_seg = ref_seg(m_disp, d);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b1; digit_en = 4'hF; load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (an_n !== 4'hF || seg_n !== 7'h7F) begin
        bad++;
        $display("FAIL reset_out c%0d: an_n=%h seg_n=%h want F 7f", i, an_n, seg_n);
      end
      total++;
      if (load_ready !== 1'b1 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hs c%0d: ready=%b fd=%b want 1 0", i, load_ready, frame_done);
      end
    end
  endtask

  task automatic test_scan();
    int fd_cnt = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        bad++;
        $display("FAIL scan_out c%0d: an_n=%h seg_n=%h want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
      total++;
      if (load_ready !== exp_ready || frame_done !== exp_fd) begin
        bad++;
        $display("FAIL scan_hs c%0d: ready=%b fd=%b want %b %b", i, load_ready, frame_done,
                 exp_ready, exp_fd);
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (i == 2 || i == 10) begin
        total++;
        if (an_n !== ((i == 2) ? 4'hE : 4'hD)) begin
          bad++;
          $display("FAIL scan_first_digit c%0d: an_n=%h want %h", i, an_n, (i == 2) ? 4'hE : 4'hD);
        end
      end
    end
    total++;
    if (fd_cnt != 2) begin
      bad++;
      $display("FAIL scan_frame_count: got=%0d want 2", fd_cnt);
    end
  endtask

  task automatic test_load();
    bit seen4 = 1'b0;
    bit seen1 = 1'b0;
    digit_en = 4'hF;
    load_data = 16'h1234; load_valid = 1'b1;
    for (int i = 0; i < 61; i++) begin
      tick();
      load_valid = 1'b0;
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        bad++;
        $display("FAIL load_out c%0d: an_n=%h seg_n=%h want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
      total++;
      if (load_ready !== exp_ready || frame_done !== exp_fd) begin
        bad++;
        $display("FAIL load_hs c%0d: ready=%b fd=%b want %b %b", i, load_ready, frame_done,
                 exp_ready, exp_fd);
      end
      if (an_n === 4'hE && seg_n === 7'h19) seen4 = 1'b1;
      if (an_n === 4'h7 && seg_n === 7'h79) seen1 = 1'b1;
    end
    total++;
    if (!seen4 || !seen1) begin
      bad++;
      $display("FAIL load_shown: digit0_4=%b digit3_1=%b want 1 1", seen4, seen1);
    end
  endtask

  task automatic test_back_to_back();
    bit prev_ready;
    int rise = -1;
    int fall = -1;
    bit seen_a = 1'b0;
    bit seen_5 = 1'b0;
    prev_ready = load_ready;
    load_data = 16'hAAAA; load_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        bad++;
        $display("FAIL b2b_out c%0d: an_n=%h seg_n=%h want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
      total++;
      if (load_ready !== exp_ready || frame_done !== exp_fd) begin
        bad++;
        $display("FAIL b2b_hs c%0d: ready=%b fd=%b want %b %b", i, load_ready, frame_done,
                 exp_ready, exp_fd);
      end
      if (i > 0 && !prev_ready && load_ready === 1'b1 && rise < 0) rise = i;
      if (rise >= 0 && fall < 0 && prev_ready && load_ready === 1'b0) fall = i;
      prev_ready = load_ready;
      if (an_n === 4'hE && seg_n === 7'h08) seen_a = 1'b1;
      if (an_n === 4'hE && seg_n === 7'h12) seen_5 = 1'b1;
      if (m_pflag && m_pend == 16'hAAAA) load_data = 16'h5555;
    end
    load_valid = 1'b0;
    total++;
    if (rise < 0 || fall != rise + 1) begin
      bad++;
      $display("FAIL b2b_reaccept: ready rose c%0d fell c%0d want fall=rise+1", rise, fall);
    end
    total++;
    if (!seen_a || !seen_5) begin
      bad++;
      $display("FAIL b2b_frames: saw_A=%b saw_5=%b want 1 1", seen_a, seen_5);
    end
  endtask

  task automatic test_mask_disable();
    bit found = 1'b0;
    digit_en = 4'b1011;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg || an_n === 4'b1011) begin
        bad++;
        $display("FAIL mask_out c%0d: an_n=%h seg_n=%h want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
      if (i >= 40 && !m_off && (m_t / 8) % 4 == 2 && m_t % 8 == 4) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mask_wait_digit2: timed out, got=0 want 1");
    end
    scan_en = 1'b0;
    tick();
    total++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL disable_dark: an_n=%h seg_n=%h fd=%b want F 7f 0", an_n, seg_n, frame_done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg || load_ready !== exp_ready || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL off_out c%0d: an_n=%h seg_n=%h ready=%b want %h %h %b", i, an_n, seg_n,
                 load_ready, exp_an, exp_seg, exp_ready);
      end
    end
    scan_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (an_n !== ((i < 2) ? 4'hF : 4'hE)) begin
        bad++;
        $display("FAIL restart c%0d: an_n=%h want %h", i, an_n, (i < 2) ? 4'hF : 4'hE);
      end
    end
  endtask

`ifdef SEG_LZ_BLANK_EN
  task automatic test_lz();
    bit [3:0] seen = 4'h0;
    digit_en = 4'hF;
    load_data = 16'h0050; load_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        bad++;
        $display("FAIL lz_out c%0d: an_n=%h seg_n=%h want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
      if (i > 70) begin
        if (an_n === 4'h7 && seg_n === 7'h7F) seen[3] = 1'b1;
        if (an_n === 4'hB && seg_n === 7'h7F) seen[2] = 1'b1;
        if (an_n === 4'hD && seg_n === 7'h12) seen[1] = 1'b1;
        if (an_n === 4'hE && seg_n === 7'h40) seen[0] = 1'b1;
      end
    end
    load_valid = 1'b0;
    total++;
    if (seen !== 4'hF) begin
      bad++;
      $display("FAIL lz_digits: seen=%b want 1111", seen);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (i % 16 == 0) scan_en = ($urandom_range(0, 5) != 0);
      if (i % 7 == 0) digit_en = 4'($urandom);
      load_valid = ($urandom_range(0, 2) == 0);
      load_data = 16'($urandom);
      tick();
      total++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        bad++;
        $display("FAIL rand_out c%0d: an_n=%h seg_n=%h want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
      total++;
      if (load_ready !== exp_ready || frame_done !== exp_fd) begin
        bad++;
        $display("FAIL rand_hs c%0d: ready=%b fd=%b want %b %b", i, load_ready, frame_done,
                 exp_ready, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_mask_disable();
`ifdef SEG_LZ_BLANK_EN
    test_lz();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
